frame_disassembly_fsm: RTL and testbench
========================================

FRAME_DISASSEMBLY_FSM -- requirements
Module: frame_disassembly_fsm

Interface
REQ-001 The block SHALL take parameter IMG_W, default 240, image width in pixels.
REQ-002 The block SHALL take parameter IMG_H, default 170, image height in pixels.
REQ-003 The block SHALL take parameter HEADER, default 8'hAA, frame start byte.
REQ-004 The block SHALL derive localparam NPIX = IMG_W*IMG_H and AW = $clog2(NPIX).
REQ-005 clk  input  1  single system clock; all logic is on the rising edge.
REQ-006 reset  input  1  asynchronous, active-high reset.
REQ-007 start  input  1  one-cycle request to transmit one stored frame.
REQ-008 full  input  1  TX byte FIFO full flag.
REQ-009 push  output  1  one-cycle byte write strobe to the TX FIFO.
REQ-010 push_data  output  8  byte written when push=1.
REQ-011 oe  output  1  image RAM read enable.
REQ-012 rAddr  output  AW  image RAM read address, 0..NPIX-1.
REQ-013 imgData  input  24  RAM read data {R[23:16],G[15:8],B[7:0]}, valid the cycle after oe=1.
REQ-014 busy  output  1  high from start acceptance until frame_tx_done.
REQ-015 frame_tx_done  output  1  one-cycle pulse after the last byte of a frame is pushed.

Function
REQ-016 The FSM SHALL have states IDLE, HDR, READ, WAIT, SEND_R, SEND_G, SEND_B, DONE.
REQ-017 IDLE: start=1 -> HDR, pixel counter cleared to 0, busy=1 from the next cycle; start=0 -> stay.
REQ-018 start SHALL be ignored in every state other than IDLE.
REQ-019 HDR: when full=0, push=1 with push_data=HEADER, then -> READ; when full=1, stay with push=0.
REQ-020 READ: oe=1, rAddr=pixel counter, for exactly one cycle, then -> WAIT.
REQ-021 WAIT: imgData latched into a 24-bit pixel register at the end of the cycle, then -> SEND_R.
REQ-022 SEND_R/SEND_G/SEND_B: push bytes imgData[23:16], [15:8], [7:0] of the latched pixel, in that order.
REQ-023 Each SEND state SHALL push only when full=0, advancing on that cycle; with full=1 it SHALL hold, push=0, push_data unchanged.
REQ-024 SEND_B with push: counter < NPIX-1 -> counter+1, -> READ; counter = NPIX-1 -> DONE.
REQ-025 DONE: frame_tx_done=1 for one cycle, busy=0 in that cycle, -> IDLE.
REQ-026 Exactly 1+3*NPIX pushes (122401 at default parameters) SHALL occur per frame; there are no duplicate or skipped pixels.
REQ-027 push SHALL never be 1 in a cycle where full=1.
REQ-028 oe SHALL be 0 outside READ; rAddr SHALL hold its last value when oe=0.
REQ-029 The pixel counter SHALL be AW bits wide and never exceed NPIX-1; it SHALL not wrap.
REQ-030 Throughput with full=0 throughout SHALL be 5 cycles per pixel (READ, WAIT, 3 SEND).

Reset
REQ-031 reset=1 SHALL force state IDLE, counter 0, and pixel register 0 immediately.
REQ-032 reset=1 SHALL force push, push_data, oe, rAddr, busy, and frame_tx_done to 0 immediately.
REQ-033 Reset mid-frame SHALL abandon the frame with no further pushes; the next start restarts from the header and pixel 0.

Verification
REQ-034 IMG_W=2, IMG_H=2, RAM preloaded 0x010203,0x040506,0x070809,0x0A0B0C, full=0, start pulse -> pushes AA,01,02,03,04,05,06,07,08,09,0A,0B,0C on consecutive-as-allowed cycles, then one frame_tx_done pulse.
REQ-035 Same setup with full driven high for 3 cycles during SEND_G of pixel 1 -> push=0 during those cycles, the byte sequence is identical, and there is no push while full=1.
REQ-036 start pulsed again while busy=1 -> ignored; exactly 13 pushes and one frame_tx_done.
REQ-037 Reset asserted after the 6th push -> all outputs 0 at once; new start -> the sequence restarts at AA, 01.
REQ-038 Default parameters with a RAM holding address-derived data and a FIFO model never full -> 122401 pushes, last three bytes equal RAM[40799], rAddr maximum 40799.
REQ-039 Loopback: a scoreboard fed through a uart_tx -> uart_rx_fifo -> data_assembly_fsm -> img_ram chain SHALL rebuild identical RAM contents and assert o_frame_done.

Source files
------------

// File: rtl/frame_disassembly_fsm.sv
// Streams one stored RGB frame from the image RAM into a TX byte FIFO:
// a header byte, then R, G, B for every pixel in raster order.
module frame_disassembly_fsm #(
    parameter int          IMG_W  = 240,
    parameter int          IMG_H  = 170,
    parameter logic [7:0]  HEADER = 8'hAA,
    localparam int         NPIX   = IMG_W * IMG_H,
    localparam int         AW     = $clog2(NPIX)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic          full,
    output logic          push,
    output logic [7:0]    push_data,
    output logic          oe,
    output logic [AW-1:0] rAddr,
    input  logic [23:0]   imgData,
    output logic          busy,
    output logic          frame_tx_done
);

    localparam logic [AW-1:0] LAST_PIX = AW'(NPIX - 1);

    typedef enum logic [2:0] {
        IDLE,
        HDR,
        READ,
        WAIT,
        SEND_R,
        SEND_G,
        SEND_B,
        DONE
    } state_t;

    state_t          state;
    logic [AW-1:0]   pix_cnt;
    logic [23:0]     pix_reg;
    logic            push_en;

    // The strobe is gated by full in the same cycle so a byte is never
    // offered to a FIFO that has just filled up.
    assign push = push_en & ~full;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            pix_cnt       <= '0;
            pix_reg       <= '0;
            push_en       <= 1'b0;
            push_data     <= '0;
            oe            <= 1'b0;
            rAddr         <= '0;
            busy          <= 1'b0;
            frame_tx_done <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    frame_tx_done <= 1'b0;
                    if (start) begin
                        state     <= HDR;
                        pix_cnt   <= '0;
                        busy      <= 1'b1;
                        push_en   <= 1'b1;
                        push_data <= HEADER;
                    end
                end
                HDR: begin
                    if (!full) begin
                        state   <= READ;
                        push_en <= 1'b0;
                        oe      <= 1'b1;
                        rAddr   <= pix_cnt;
                    end
                end
                READ: begin
                    oe    <= 1'b0;
                    state <= WAIT;
                end
                WAIT: begin
                    pix_reg   <= imgData;
                    push_en   <= 1'b1;
                    push_data <= imgData[23:16];
                    state     <= SEND_R;
                end
                SEND_R: begin
                    if (!full) begin
                        push_data <= pix_reg[15:8];
                        state     <= SEND_G;
                    end
                end
                SEND_G: begin
                    if (!full) begin
                        push_data <= pix_reg[7:0];
                        state     <= SEND_B;
                    end
                end
                SEND_B: begin
                    if (!full) begin
                        push_en <= 1'b0;
                        if (pix_cnt == LAST_PIX) begin
                            state         <= DONE;
                            busy          <= 1'b0;
                            frame_tx_done <= 1'b1;
                        end else begin
                            pix_cnt <= pix_cnt + 1'b1;
                            oe      <= 1'b1;
                            rAddr   <= pix_cnt + 1'b1;
                            state   <= READ;
                        end
                    end
                end
                DONE: begin
                    frame_tx_done <= 1'b0;
                    state         <= IDLE;
                end
                default: begin
                    state   <= IDLE;
                    push_en <= 1'b0;
                    oe      <= 1'b0;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_frame_disassembly_fsm.sv
// Scoreboard bench for frame_disassembly_fsm on a 2x2 image: expected bytes
// and frame lengths are queued by the stimulus and consumed by the monitor.
module tb_frame_disassembly_fsm;

    localparam int         IMG_W = 2;
    localparam int         IMG_H = 2;
    localparam int         NPIX  = IMG_W * IMG_H;
    localparam int         AW    = $clog2(NPIX);
    localparam logic [7:0] HDR_B = 8'hAA;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic          full = 1'b0;
    logic          push;
    logic [7:0]    push_data;
    logic          oe;
    logic [AW-1:0] rAddr;
    logic [23:0]   imgData;
    logic          busy;
    logic          frame_tx_done;

    always #5 clk = ~clk;

    frame_disassembly_fsm #(
        .IMG_W (IMG_W),
        .IMG_H (IMG_H),
        .HEADER(HDR_B)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .full         (full),
        .push         (push),
        .push_data    (push_data),
        .oe           (oe),
        .rAddr        (rAddr),
        .imgData      (imgData),
        .busy         (busy),
        .frame_tx_done(frame_tx_done)
    );

    logic [23:0] ram [NPIX];
    always @(posedge clk) if (oe) imgData <= ram[rAddr];

    logic [7:0] exp_q [$];
    int         len_q [$];
    int checks = 0, errors = 0;
    int pushes_seen = 0, done_cnt = 0, cyc = 0, hdr_cyc = 0, exp_addr = 0;
    bit timed_out = 1'b0, tmo_seen = 1'b0, fin_req = 1'b0;

    always @(posedge clk) cyc++;

    // Monitor: all comparisons happen here, on the falling edge.
    always @(negedge clk) begin
        logic [7:0] e;
        int         l;
        if (reset) begin
            checks++;
            if ({push, push_data, oe, rAddr, busy, frame_tx_done} !== '0) begin
                errors++;
                $display("FAIL reset_outputs got push=%b data=%h oe=%b addr=%0d busy=%b done=%b want all 0",
                         push, push_data, oe, rAddr, busy, frame_tx_done);
            end
        end
        if (push) begin
            pushes_seen++;
            checks++;
            if (full) begin
                errors++;
                $display("FAIL push_while_full got push=1 want 0 (data %h)", push_data);
            end
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_push got %h want no push", push_data);
            end else begin
                e = exp_q.pop_front();
                if (push_data !== e) begin
                    errors++;
                    $display("FAIL push_byte got %h want %h", push_data, e);
                end
            end
            if (push_data == HDR_B) begin
                hdr_cyc  = cyc;
                exp_addr = 0;
            end
        end
        if (oe) begin
            checks++;
            if (rAddr !== AW'(exp_addr)) begin
                errors++;
                $display("FAIL read_addr got %0d want %0d", rAddr, exp_addr);
            end
            exp_addr++;
        end
        if (frame_tx_done) begin
            done_cnt++;
            checks++;
            if (busy !== 1'b0) begin
                errors++;
                $display("FAIL busy_at_done got %b want 0", busy);
            end
            checks++;
            if (exp_q.size() != 0) begin
                errors++;
                $display("FAIL bytes_left_at_done got %0d want 0", exp_q.size());
            end
            checks++;
            if (len_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_done got pulse want none");
            end else begin
                l = len_q.pop_front();
                if (cyc - hdr_cyc != l) begin
                    errors++;
                    $display("FAIL frame_cycles got %0d want %0d", cyc - hdr_cyc, l);
                end
            end
        end
        if (timed_out && !tmo_seen) begin
            tmo_seen = 1'b1;
            checks++;
            errors++;
            $display("FAIL timeout got no frame_tx_done want pulse");
        end
        if (fin_req) begin
            checks++;
            if (exp_q.size() != 0) begin
                errors++;
                $display("FAIL bytes_never_pushed got %0d want 0", exp_q.size());
            end
            checks++;
            if (len_q.size() != 0) begin
                errors++;
                $display("FAIL frames_never_done got %0d want 0", len_q.size());
            end
            $display("CHECKS %0d ERRORS %0d", checks, errors);
            $finish;
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic queue_frame(input int extra_cycles);
        exp_q.push_back(HDR_B);
        for (int i = 0; i < NPIX; i++) begin
            exp_q.push_back(ram[i][23:16]);
            exp_q.push_back(ram[i][15:8]);
            exp_q.push_back(ram[i][7:0]);
        end
        len_q.push_back(1 + 5 * NPIX + extra_cycles);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step(1);
        start = 1'b0;
    endtask

    task automatic wait_done(input int target, input int max_cycles);
        for (int i = 0; i < max_cycles && done_cnt < target; i++) step(1);
        if (done_cnt < target) timed_out = 1'b1;
    endtask

    initial begin
        int  base;
        bit  found;
        ram[0] = 24'h010203;
        ram[1] = 24'h040506;
        ram[2] = 24'h070809;
        ram[3] = 24'h0A0B0C;
        reset = 1'b1;
        step(3);
        reset = 1'b0;
        step(1);

        // Plain frame, FIFO never full.
        queue_frame(0);
        pulse_start();
        wait_done(1, 200);
        step(3);

        // Full held for 3 cycles while G of pixel 1 is pending.
        queue_frame(3);
        pulse_start();
        found = 1'b0;
        for (int i = 0; i < 200 && !found; i++) begin
            if (push && push_data == 8'h05) found = 1'b1;
            else step(1);
        end
        if (found) begin
            full = 1'b1;
            step(3);
            full = 1'b0;
        end else begin
            timed_out = 1'b1;
        end
        wait_done(2, 200);
        step(3);

        // Repeated start requests while busy are ignored.
        queue_frame(0);
        pulse_start();
        step(4);
        pulse_start();
        step(8);
        pulse_start();
        wait_done(3, 200);
        step(30);

        // Reset after the sixth push abandons the frame.
        exp_q.push_back(HDR_B);
        exp_q.push_back(8'h01);
        exp_q.push_back(8'h02);
        exp_q.push_back(8'h03);
        exp_q.push_back(8'h04);
        exp_q.push_back(8'h05);
        base = pushes_seen;
        pulse_start();
        for (int i = 0; i < 200 && pushes_seen < base + 6; i++) step(1);
        if (pushes_seen < base + 6) timed_out = 1'b1;
        reset = 1'b1;
        step(2);
        reset = 1'b0;
        step(10);
        queue_frame(0);
        pulse_start();
        wait_done(4, 200);
        step(5);

        fin_req = 1'b1;
        step(5);
        $display("FAIL summary_not_reached got no summary want summary");
        $fatal(1);
    end

endmodule
